// File: rtl/ucsbece154b_pkg.sv
// Shared front-end definitions.
//   fetch_state_e : fetch FSM states
//   fetch_entry_t : {pc, instr} record pushed into the instruction queue
//   DEFAULT_RESET_PC / PC_INCR : reset PC and sequential PC step
package ucsbece154b_pkg;

    localparam int unsigned FETCH_XLEN       = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0001_0000;
    localparam int unsigned PC_INCR          = 4;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_WAIT,
        F_DROP
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ucsbece154b_fetch_unit.sv
// Fetch stage: issues one instruction-memory request at a time (req/gnt/rvalid)
// and pushes {pc, instr} into the instruction queue. A redirect kills any
// in-flight fetch and resumes at the (word-aligned) target PC.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   fetch_en_i                   allow new requests
//   redirect_i, redirect_pc_i    redirect strobe and target
//   imem_req_o, imem_addr_o      request to instruction memory
//   imem_gnt_i                   request accepted
//   imem_rvalid_i, imem_rdata_i  response
//   fq_full_i                    instruction queue full
//   fq_push_o, fq_data_o         push {pc, instr} into the queue
//   busy_o                       request or response outstanding
module ucsbece154b_fetch_unit
    import ucsbece154b_pkg::*;
#(
    parameter int unsigned     XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_en_i,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    output logic              imem_req_o,
    output logic [XLEN-1:0]   imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [XLEN-1:0]   imem_rdata_i,
    input  logic              fq_full_i,
    output logic              fq_push_o,
    output logic [2*XLEN-1:0] fq_data_o,
    output logic              busy_o
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic            resp_take;

    // A response is kept only if nothing redirected the front end in the meantime
    // (DROP covers earlier redirects, redirect_i covers this cycle).
    assign resp_take   = (state_q == F_WAIT) && imem_rvalid_i && !redirect_i;

    assign imem_req_o  = (state_q == F_REQ);
    assign imem_addr_o = pc_q;
    assign fq_push_o   = resp_take;
    assign fq_data_o   = resp_take ? {pc_q, imem_rdata_i} : '0;
    assign busy_o      = (state_q != F_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= F_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            if (redirect_i)
                pc_q <= redirect_pc_i & ~(XLEN'(3));
            else if (resp_take)
                pc_q <= pc_q + XLEN'(PC_INCR);

            unique case (state_q)
                F_IDLE: if (fetch_en_i && !fq_full_i && !redirect_i) state_q <= F_REQ;
                // Request is held until granted; only a redirect may withdraw it.
                // A grant coinciding with a redirect leaves a response to discard.
                F_REQ: begin
                    if (imem_gnt_i)      state_q <= redirect_i ? F_DROP : F_WAIT;
                    else if (redirect_i) state_q <= F_IDLE;
                end
                // Always pass through IDLE after a response so the full flag is
                // re-sampled after our own push has landed in the queue.
                F_WAIT: begin
                    if (imem_rvalid_i)   state_q <= F_IDLE;
                    else if (redirect_i) state_q <= F_DROP;
                end
                F_DROP: if (imem_rvalid_i) state_q <= F_IDLE;
                default: state_q <= F_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ucsbece154b_fetch_unit.sv
// Bench for ucsbece154b_fetch_unit: memory and 4-entry queue are modelled here;
// a transaction-level scoreboard tracks the PC of the next instruction to be
// delivered and which memory responses are still wanted.
module tb_ucsbece154b_fetch_unit;
    import ucsbece154b_pkg::*;

    localparam int FQ_DEPTH = 4;

    logic        clk_i, rst_i, fetch_en_i, redirect_i;
    logic [31:0] redirect_pc_i, imem_addr_o, imem_rdata_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i, fq_full_i, fq_push_o, busy_o;
    logic [63:0] fq_data_o;

    ucsbece154b_fetch_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .fetch_en_i(fetch_en_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .fq_full_i(fq_full_i), .fq_push_o(fq_push_o), .fq_data_o(fq_data_o),
        .busy_o(busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_pass = 0;

    // stimulus knobs
    logic        fetch_en = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    int          gnt_dly = 0, rsp_lat = 1, pop_mode = 1;
    bit          mem_rand = 1'b0, pop_once = 1'b0;

    // memory / queue / scoreboard state
    int          gnt_wait, rsp_wait, fq_cnt, cyc, push_cnt, req_cnt, first_push;
    bit          rsp_live, hold;
    logic [31:0] rsp_addr, hold_addr, exp_pc, last_pc;

    function automatic logic [31:0] instr_of(logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic do_reset();
        fetch_en_i = 0; redirect_i = 0; redirect_pc_i = 0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0; fq_full_i = 0;
        rst_i = 1'b1;
        #1;
        chk("rst_req",  64'(imem_req_o), 64'd0);
        chk("rst_push", 64'(fq_push_o), 64'd0);
        chk("rst_data", fq_data_o, 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_addr", 64'(imem_addr_o), 64'(DEFAULT_RESET_PC));
        repeat (2) @(posedge clk_i);
        exp_pc = DEFAULT_RESET_PC; rsp_wait = -1; rsp_live = 0; fq_cnt = 0; hold = 0;
        gnt_wait = mem_rand ? int'($urandom_range(0, 3)) : gnt_dly;
        cyc = 0; push_cnt = 0; req_cnt = 0; first_push = -1; last_pc = 32'hx;
        redirect = 0; pop_once = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, advance model.
    task automatic cycle();
        logic req, gnt, rv, push;
        fetch_entry_t e;
        int pre;
        bit pop;
        @(negedge clk_i);
        imem_gnt_i    = imem_req_o && (gnt_wait == 0);
        imem_rvalid_i = (rsp_wait == 0);
        imem_rdata_i  = imem_rvalid_i ? instr_of(rsp_addr) : 32'h0;
        fq_full_i     = (fq_cnt == FQ_DEPTH);
        fetch_en_i    = fetch_en;
        redirect_i    = redirect;
        redirect_pc_i = redirect_pc;
        #1;
        cyc++;
        req = imem_req_o; gnt = imem_gnt_i; rv = imem_rvalid_i; push = fq_push_o;
        if (req) req_cnt++;
        chk("busy", 64'(busy_o), 64'(req || rsp_wait >= 0));
        chk("push", 64'(push), 64'(rv && rsp_live && !redirect));
        if (push) begin
            e = fq_data_o;
            chk("push_pc", 64'(e.pc), 64'(exp_pc));
            chk("push_instr", 64'(e.instr), 64'(instr_of(exp_pc)));
            chk("push_while_full", 64'(fq_full_i), 64'd0);
            push_cnt++; last_pc = e.pc;
            if (first_push < 0) first_push = cyc;
        end
        if (req) chk("req_while_full", 64'(fq_full_i), 64'd0);
        if (hold) begin
            chk("req_hold", 64'(req), 64'd1);
            chk("addr_hold", 64'(imem_addr_o), 64'(hold_addr));
        end
        if (gnt && !redirect) chk("gnt_addr", 64'(imem_addr_o), 64'(exp_pc));
        // model update
        hold = req && !gnt && !redirect; hold_addr = imem_addr_o;
        if (redirect) exp_pc = redirect_pc & ~32'h3;
        else if (push) exp_pc = exp_pc + 32'd4;
        if (rv) rsp_wait = -1;
        else if (rsp_wait > 0) rsp_wait--;
        if (redirect) rsp_live = 0;
        if (gnt) begin
            rsp_wait = (mem_rand ? int'($urandom_range(1, 3)) : rsp_lat) - 1;
            rsp_live = !redirect;
            rsp_addr = imem_addr_o;
            gnt_wait = mem_rand ? int'($urandom_range(0, 3)) : gnt_dly;
        end else if (req && gnt_wait > 0) gnt_wait--;
        pop = (pop_mode == 1) || pop_once || (pop_mode == 2 && $urandom_range(0, 1) == 1);
        pre = fq_cnt;
        if (push) fq_cnt++;
        if (pop && pre > 0) fq_cnt--;
        redirect = 0; pop_once = 0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_push(int n, string nm);
        int k = 0;
        while (push_cnt < n && k < 40) begin cycle(); k++; end
        chk(nm, 64'(push_cnt >= n), 64'd1);
    endtask

    typedef struct {
        int          g, l, ncyc;
        int          exp_pushes, exp_first;
        logic [31:0] exp_last;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int n0, k;
        rst_i = 1'b1;
        // steady-state fetch: push period = 2 + gnt delay + response latency
        vecs[0] = '{g: 0, l: 1, ncyc: 9,  exp_pushes: 3, exp_first: 3, exp_last: 32'h0001_0008};
        vecs[1] = '{g: 3, l: 1, ncyc: 12, exp_pushes: 2, exp_first: 6, exp_last: 32'h0001_0004};
        vecs[2] = '{g: 0, l: 3, ncyc: 20, exp_pushes: 4, exp_first: 5, exp_last: 32'h0001_000C};
        vecs[3] = '{g: 2, l: 2, ncyc: 13, exp_pushes: 2, exp_first: 6, exp_last: 32'h0001_0004};

        for (int i = 0; i < 4; i++) begin
            gnt_dly = vecs[i].g; rsp_lat = vecs[i].l; pop_mode = 1; mem_rand = 0;
            do_reset();
            fetch_en = 1;
            repeat (vecs[i].ncyc) cycle();
            chk($sformatf("vec%0d_pushes", i), 64'(push_cnt), 64'(vecs[i].exp_pushes));
            chk($sformatf("vec%0d_first", i), 64'(first_push), 64'(vecs[i].exp_first));
            chk($sformatf("vec%0d_last", i), 64'(last_pc), 64'(vecs[i].exp_last));
        end

        // queue fills, fetch stalls, one pop lets exactly one more through
        gnt_dly = 0; rsp_lat = 1; pop_mode = 0;
        do_reset(); fetch_en = 1;
        repeat (12) cycle();
        chk("fill_pushes", 64'(push_cnt), 64'd4);
        req_cnt = 0;
        repeat (6) cycle();
        chk("full_no_req", 64'(req_cnt), 64'd0);
        pop_once = 1;
        repeat (8) cycle();
        chk("pop_one_push", 64'(push_cnt), 64'd5);
        chk("pop_one_pc", 64'(last_pc), 64'h0001_0010);

        // redirect while waiting for the response
        gnt_dly = 0; rsp_lat = 3; pop_mode = 1;
        do_reset(); fetch_en = 1;
        repeat (2) cycle();
        redirect = 1; redirect_pc = 32'h0000_2000;
        cycle();
        wait_push(1, "wait_redir_timeout");
        chk("wait_redir_pc", 64'(last_pc), 64'h2000);

        // redirect in the same cycle as rvalid
        rsp_lat = 1;
        do_reset(); fetch_en = 1;
        repeat (2) cycle();
        redirect = 1; redirect_pc = 32'h0000_4000;
        cycle();
        chk("rv_redir_nopush", 64'(push_cnt), 64'd0);
        wait_push(1, "rv_redir_timeout");
        chk("rv_redir_pc", 64'(last_pc), 64'h4000);

        // slow grant, then redirect withdraws the pending request
        gnt_dly = 3;
        do_reset(); fetch_en = 1;
        repeat (3) cycle();
        redirect = 1; redirect_pc = 32'h0000_3002;
        cycle();
        chk("withdraw", 64'(imem_req_o), 64'd0);
        k = 0;
        while (!imem_req_o && k < 20) begin cycle(); k++; end
        chk("new_req_addr", 64'(imem_addr_o), 64'h3000);
        wait_push(1, "withdraw_timeout");
        chk("withdraw_pc", 64'(last_pc), 64'h3000);

        // asynchronous reset mid-WAIT, then PC wrap
        gnt_dly = 0; rsp_lat = 3;
        do_reset(); fetch_en = 1;
        repeat (2) cycle();
        #2;
        chk("busy_pre_rst", 64'(busy_o), 64'd1);
        do_reset(); fetch_en = 1;
        wait_push(1, "restart_timeout");
        chk("restart_pc", 64'(last_pc), 64'(DEFAULT_RESET_PC));
        redirect = 1; redirect_pc = 32'hFFFF_FFFE;
        cycle();
        n0 = push_cnt;
        wait_push(n0 + 1, "wrap_timeout0");
        chk("wrap_pc0", 64'(last_pc), 64'hFFFF_FFFC);
        wait_push(n0 + 2, "wrap_timeout1");
        chk("wrap_pc1", 64'(last_pc), 64'h0);

        // random traffic against the scoreboard
        mem_rand = 1; pop_mode = 2;
        do_reset();
        repeat (3000) begin
            fetch_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect = 1; redirect_pc = $urandom;
            end
            cycle();
        end
        chk("rand_progress", 64'(push_cnt > 50), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
